// File: rtl/uart_word_rx_if.sv
// Holding-register side of uart_word_rx: received word, valid/ready handshake
// and the one-cycle status pulses.
interface uart_word_rx_if #(
    parameter int DATA_WIDTH = 25
);
    logic [DATA_WIDTH-1:0] data_output;
    logic                  data_valid;
    logic                  data_ready;
    logic                  frame_err;
    logic                  parity_err;
    logic                  overrun;

    // master: the receiver that fills the holding register
    modport master (
        output data_output,
        output data_valid,
        output frame_err,
        output parity_err,
        output overrun,
        input  data_ready
    );

    // slave: the consumer (bus-side command decoder)
    modport slave (
        input  data_output,
        input  data_valid,
        input  frame_err,
        input  parity_err,
        input  overrun,
        output data_ready
    );
endinterface

// File: rtl/uart_word_rx.sv
// Wide-word UART receiver: start, DATA_WIDTH data bits LSB first, optional even
// parity (compile with UART_RX_PARITY_EN), one stop bit; word held on valid/ready.
module uart_word_rx #(
    parameter int CLOCKS_PER_PULSE = 5208,
    parameter int DATA_WIDTH       = 25
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           rx,
    uart_word_rx_if.master bus
);

    localparam int CNT_W = $clog2(CLOCKS_PER_PULSE);
    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLOCKS_PER_PULSE - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLOCKS_PER_PULSE / 2 - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t state, state_next;

    logic                  rx_meta;
    logic                  rx_s;
    logic [CNT_W-1:0]      cnt;
    logic [IDX_W-1:0]      idx;
    logic [DATA_WIDTH-1:0] shift;
    logic [DATA_WIDTH-1:0] shift_in;

    logic cnt_clear;
    logic shift_en;
    logic deliver;
    logic frame_fail;
    logic load;

    logic [DATA_WIDTH-1:0] data_q;
    logic                  valid_q;
    logic                  frame_err_q;
    logic                  overrun_q;

`ifdef UART_RX_PARITY_EN
    logic par_en;
    logic par_bad;
    logic parity_fail;
    logic parity_err_q;
`endif

    // NOTE: both synchronizer flops reset to 1 (line idle), so leaving reset
    // can never be mistaken for the falling edge of a start bit.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        cnt_clear  = 1'b0;
        shift_en   = 1'b0;
        deliver    = 1'b0;
        frame_fail = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_en      = 1'b0;
        parity_fail = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (!rx_s) begin
                    state_next = S_START;
                    cnt_clear  = 1'b1;
                end
            end
            // Half a bit in: a line that is high again was only a glitch.
            S_START: begin
                if (cnt == HALF_LAST) begin
                    cnt_clear  = 1'b1;
                    state_next = rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_clear = 1'b1;
                    shift_en  = 1'b1;
                    if (idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_next = S_PARITY;
`else
                        state_next = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (cnt == BIT_LAST) begin
                    cnt_clear  = 1'b1;
                    par_en     = 1'b1;
                    state_next = S_STOP;
                end
            end
`endif
            // A low stop bit outranks a parity mismatch for the same frame.
            S_STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_clear = 1'b1;
                    if (!rx_s) begin
                        frame_fail = 1'b1;
                        state_next = S_WAIT_HIGH;
                    end
`ifdef UART_RX_PARITY_EN
                    else if (par_bad) begin
                        parity_fail = 1'b1;
                        state_next  = S_IDLE;
                    end
`endif
                    else begin
                        deliver    = 1'b1;
                        state_next = S_IDLE;
                    end
                end
            end
            // Hold off until the line idles so a break is not read as new starts.
            S_WAIT_HIGH: begin
                if (rx_s) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    generate
        if (DATA_WIDTH == 1) begin : g_shift_one
            assign shift_in = rx_s;
        end else begin : g_shift_wide
            assign shift_in = {rx_s, shift[DATA_WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt   <= '0;
            idx   <= '0;
            shift <= '0;
        end else begin
            cnt <= cnt_clear ? '0 : cnt + 1'b1;
            if (state != S_DATA) begin
                idx <= '0;
            end else if (shift_en) begin
                idx <= idx + 1'b1;
            end
            if (shift_en) begin
                shift <= shift_in;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    // Even parity: the received bit must equal the XOR of the data bits.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            par_bad      <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            if (par_en) begin
                par_bad <= rx_s ^ (^shift);
            end
            parity_err_q <= parity_fail;
        end
    end
    assign bus.parity_err = parity_err_q;
`else
    assign bus.parity_err = 1'b0;
`endif

    // A new word may replace the held one only if it is being accepted now.
    assign load = deliver && (!valid_q || bus.data_ready);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frame_err_q <= frame_fail;
            overrun_q   <= deliver && !load;
            if (load) begin
                data_q  <= shift;
                valid_q <= 1'b1;
            end else if (valid_q && bus.data_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.data_output = data_q;
    assign bus.data_valid  = valid_q;
    assign bus.frame_err   = frame_err_q;
    assign bus.overrun     = overrun_q;

endmodule

// File: tb/tb_uart_word_rx.sv
// Randomized bench for uart_word_rx: serial frames scored against an event-level
// model of delivery, flags and the valid/ready holding register.
module tb_uart_word_rx;

    localparam int CPP = 16;
    localparam int DW  = 25;
`ifdef UART_RX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    // posedges from the negedge that drops rx to the edge the outcome appears
    localparam int FRAME_EDGES = 3 + CPP / 2 + (DW + P + 1) * CPP;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    logic rx   = 1'b1;

    uart_word_rx_if #(.DATA_WIDTH(DW)) bus ();

    uart_word_rx #(
        .CLOCKS_PER_PULSE(CPP),
        .DATA_WIDTH      (DW)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .rx  (rx),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef enum {EV_GOOD, EV_FRAME, EV_PARITY} ev_kind_t;
    typedef struct {
        int            edge_no;
        ev_kind_t      kind;
        logic [DW-1:0] word;
    } ev_t;

    ev_t evq[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int ready_mode = 1;  // 0: hold low, 1: hold high, 2: random each cycle

    logic          m_valid = 1'b0;
    logic [DW-1:0] m_data  = '0;
    logic          e_fe = 1'b0;
    logic          e_pe = 1'b0;
    logic          e_ov = 1'b0;
    logic          m_accept;
    logic          m_loaded;
    ev_t           m_ev;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    // Reference model: each frame's outcome lands at one known edge.
    always @(posedge clk) begin
        cyc++;
        e_fe = 1'b0;
        e_pe = 1'b0;
        e_ov = 1'b0;
        if (!rstn) begin
            m_valid = 1'b0;
            m_data  = '0;
        end else begin
            m_accept = m_valid && bus.data_ready;
            m_loaded = 1'b0;
            if (evq.size() > 0 && evq[0].edge_no == cyc) begin
                m_ev = evq.pop_front();
                case (m_ev.kind)
                    EV_FRAME:  e_fe = 1'b1;
                    EV_PARITY: e_pe = 1'b1;
                    default: begin
                        if (!m_valid || bus.data_ready) begin
                            m_data   = m_ev.word;
                            m_valid  = 1'b1;
                            m_loaded = 1'b1;
                        end else begin
                            e_ov = 1'b1;
                        end
                    end
                endcase
            end
            if (m_accept && !m_loaded) m_valid = 1'b0;
        end
    end

    always @(negedge clk) begin
        check("status{valid,ferr,perr,ovr}",
              {60'd0, bus.data_valid, bus.frame_err, bus.parity_err, bus.overrun},
              {60'd0, m_valid, e_fe, e_pe, e_ov});
        check("data_output", {39'd0, bus.data_output}, {39'd0, m_data});
    end

    always @(negedge clk) begin
        case (ready_mode)
            0:       bus.data_ready = 1'b0;
            1:       bus.data_ready = 1'b1;
            default: bus.data_ready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic send_bit(input logic b);
        @(negedge clk);
        rx = b;
        repeat (CPP - 1) @(negedge clk);
    endtask

    task automatic send_frame(input logic [DW-1:0] w, input bit stop_bit, input bit par_flip);
        ev_t ev;
        @(negedge clk);
        rx         = 1'b0;
        ev.edge_no = cyc + FRAME_EDGES;
        ev.word    = w;
        if (!stop_bit)                ev.kind = EV_FRAME;
        else if (par_flip && (P == 1)) ev.kind = EV_PARITY;
        else                           ev.kind = EV_GOOD;
        evq.push_back(ev);
        repeat (CPP - 1) @(negedge clk);
        for (int i = 0; i < DW; i++) send_bit(w[i]);
        if (P == 1) send_bit((^w) ^ par_flip);
        send_bit(stop_bit);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        rx = 1'b1;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic glitch(input int len);
        @(negedge clk);
        rx = 1'b0;
        repeat (len - 1) @(negedge clk);
        idle(CPP);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        #2;
        rstn    = 1'b0;
        rx      = 1'b1;
        m_valid = 1'b0;
        m_data  = '0;
        e_fe    = 1'b0;
        e_pe    = 1'b0;
        e_ov    = 1'b0;
        evq.delete();
        repeat (5) @(negedge clk);
        #2;
        rstn = 1'b1;
    endtask

    initial begin
        logic [DW-1:0] w;
        logic [DW-1:0] abort_word;
        int            r;

        bus.data_ready = 1'b1;
        repeat (4) @(negedge clk);
        #2;
        rstn = 1'b1;
        idle(CPP);

        // Basic frame with the consumer always ready.
        ready_mode = 1;
        send_frame(25'h15234A5, 1'b1, 1'b0);
        idle(2 * CPP);

        // Short low pulse is a glitch; the next frame still lands.
        glitch(4);
        send_frame(25'h0000001, 1'b1, 1'b0);
        idle(2 * CPP);

        // Framing error followed by a held-low line, then a clean frame.
        send_frame(25'h1FFFFFF, 1'b0, 1'b0);
        repeat (40) @(negedge clk);
        idle(2 * CPP);
        send_frame(25'h0AAAAAA, 1'b1, 1'b0);
        idle(2 * CPP);

        // Overrun: second word dropped while the first is held.
        ready_mode = 0;
        send_frame(25'h0000011, 1'b1, 1'b0);
        idle(2);
        send_frame(25'h0000022, 1'b1, 1'b0);
        idle(4 * CPP);
        ready_mode = 1;
        idle(4);

        // Reset in the middle of data bit 10, then a fresh frame.
        abort_word = 25'h1555555;
        @(negedge clk);
        rx = 1'b0;
        repeat (CPP - 1) @(negedge clk);
        for (int i = 0; i < 10; i++) send_bit(abort_word[i]);
        @(negedge clk);
        rx = abort_word[10];
        repeat (CPP / 2) @(negedge clk);
        apply_reset();
        idle(2 * CPP);
        send_frame(25'h1234567, 1'b1, 1'b0);
        idle(2 * CPP);

`ifdef UART_RX_PARITY_EN
        send_frame(25'h0000003, 1'b1, 1'b1);
        idle(2 * CPP);
        send_frame(25'h0000003, 1'b1, 1'b0);
        idle(2 * CPP);
`endif

        // Random mix of frames, glitches, bad stops and ready patterns.
        ready_mode = 2;
        for (int n = 0; n < 30; n++) begin
            r = int'($urandom_range(0, 9));
            w = DW'($urandom);
            if (r == 0) begin
                glitch(int'($urandom_range(1, 6)));
            end else begin
                send_frame(w, (r != 1), (r == 2));
                if (r == 1)                    idle(4 + int'($urandom_range(0, 10)));
                else if ($urandom_range(0, 1)) idle(int'($urandom_range(1, 20)));
            end
        end
        idle(3 * CPP);
        ready_mode = 1;
        idle(4);

        check("pending_events", 64'(evq.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
